// File: rtl/x_andn_pipe.sv
// Pipelined N-operand AND/NAND reduction tree with valid/ready handshake.
// Each stage combines STAGE_FANIN operands per node; inversion is applied at the output.
module x_andn_pipe #(
    parameter int INPUTS      = 4,
    parameter int WIDTH       = 1,
    parameter int STAGE_FANIN = 2
) (
    input  logic                    CLK,
    input  logic                    SRST,
    input  logic                    CE,
    input  logic [INPUTS*WIDTH-1:0] I,
    input  logic                    INV,
    input  logic                    I_VALID,
    output logic                    I_READY,
    output logic [WIDTH-1:0]        O,
    output logic                    O_VALID,
    input  logic                    O_READY
);

    function automatic int calc_stages(input int n, input int f);
        int s;
        int c;
        s = 1;
        c = (n + f - 1) / f;
        while (c > 1) begin
            c = (c + f - 1) / f;
            s = s + 1;
        end
        return s;
    endfunction

    localparam int S = calc_stages(INPUTS, STAGE_FANIN);

    typedef logic [WIDTH-1:0] word_t;

    word_t        tap    [S+1][INPUTS];
    word_t        data_q [S][INPUTS];
    word_t        data_d [S][INPUTS];
    logic [S-1:0] valid_q, valid_d;
    logic [S-1:0] inv_q, inv_d;
    logic [S-1:0] ready;
    logic [S:0]   vtap, itap;
    word_t        fin;

    // Stage j reads tap[j]: tap[0] is the input port, tap[j+1] is stage j's registers.
    always_comb begin
        for (int k = 0; k < INPUTS; k++) begin
            tap[0][k] = I[k*WIDTH +: WIDTH];
            for (int j = 0; j < S; j++) begin
                tap[j+1][k] = data_q[j][k];
            end
        end
        vtap = {valid_q, I_VALID};
        itap = {inv_q, INV};
    end

    // A stage may load when it is empty or its successor is loading in the same cycle.
    always_comb begin
        ready      = '0;
        ready[S-1] = CE & ~SRST & (~valid_q[S-1] | O_READY);
        for (int j = S - 2; j >= 0; j--) begin
            ready[j] = CE & ~SRST & (~valid_q[j] | ready[j+1]);
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        valid_d = valid_q;
        inv_d   = inv_q;
        for (int j = 0; j < S; j++) begin
            for (int k = 0; k < INPUTS; k++) begin
                data_d[j][k] = data_q[j][k];
            end
        end
        // Nodes with no real source stay all-ones, which pads partial groups harmlessly.
        for (int j = 0; j < S; j++) begin
            if (ready[j]) begin
                valid_d[j] = vtap[j];
                inv_d[j]   = itap[j];
                for (int k = 0; k < INPUTS; k++) begin
                    data_d[j][k] = '1;
                    for (int m = 0; m < STAGE_FANIN; m++) begin
                        idx = k * STAGE_FANIN + m;
                        if (idx < INPUTS) begin
                            data_d[j][k] = data_d[j][k] & tap[j][idx];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            valid_q <= '0;
            inv_q   <= '0;
            for (int j = 0; j < S; j++) begin
                for (int k = 0; k < INPUTS; k++) begin
                    data_q[j][k] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            inv_q   <= inv_d;
            for (int j = 0; j < S; j++) begin
                for (int k = 0; k < INPUTS; k++) begin
                    data_q[j][k] <= data_d[j][k];
                end
            end
        end
    end

    // Padding nodes of the last stage are all-ones, so ANDing every node yields node 0.
    always_comb begin
        fin = '1;
        for (int k = 0; k < INPUTS; k++) begin
            fin = fin & data_q[S-1][k];
        end
        O       = '0;
        O_VALID = 1'b0;
        if (!SRST) begin
            O       = inv_q[S-1] ? ~fin : fin;
            O_VALID = valid_q[S-1];
        end
        I_READY = ready[0];
    end

endmodule

// File: tb/tb_x_andn_pipe.sv
// Scoreboard bench for x_andn_pipe: main 5x8 instance plus two degenerate configurations.
module tb_x_andn_pipe;

    localparam int N = 5;
    localparam int W = 8;
    localparam int F = 2;
    localparam int S = 3;

    logic          clk = 1'b0;
    logic          srst, ce;
    logic [N*W-1:0] i_data;
    logic          inv, i_valid, i_ready;
    logic [W-1:0]  o_data;
    logic          o_valid, o_ready;

    logic [3:0]    i_data_1, o_data_1;
    logic          inv_1, i_valid_1, i_ready_1, o_valid_1, o_ready_1;
    logic [11:0]   i_data_3;
    logic [3:0]    o_data_3;
    logic          inv_3, i_valid_3, i_ready_3, o_valid_3, o_ready_3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] val;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    x_andn_pipe #(.INPUTS(N), .WIDTH(W), .STAGE_FANIN(F)) dut (
        .CLK(clk), .SRST(srst), .CE(ce), .I(i_data), .INV(inv), .I_VALID(i_valid),
        .I_READY(i_ready), .O(o_data), .O_VALID(o_valid), .O_READY(o_ready)
    );

    x_andn_pipe #(.INPUTS(1), .WIDTH(4), .STAGE_FANIN(2)) dut_1 (
        .CLK(clk), .SRST(srst), .CE(ce), .I(i_data_1), .INV(inv_1), .I_VALID(i_valid_1),
        .I_READY(i_ready_1), .O(o_data_1), .O_VALID(o_valid_1), .O_READY(o_ready_1)
    );

    x_andn_pipe #(.INPUTS(3), .WIDTH(4), .STAGE_FANIN(4)) dut_3 (
        .CLK(clk), .SRST(srst), .CE(ce), .I(i_data_3), .INV(inv_3), .I_VALID(i_valid_3),
        .I_READY(i_ready_3), .O(o_data_3), .O_VALID(o_valid_3), .O_READY(o_ready_3)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [39:0] pack5(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [7:0] b4);
        return {b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [7:0] refAnd(input logic [39:0] ops, input logic inv_in);
        logic [7:0] r;
        r = 8'hFF;
        for (int k = 0; k < N; k++) r = r & ops[k*8 +: 8];
        return inv_in ? ~r : r;
    endfunction

    // Present one vector, hold it until accepted, and queue its expected result.
    task automatic applyStimulus(input logic [39:0] ops, input logic inv_in,
                                 input logic [7:0] expv, input bit chk_lat);
        bit   ok;
        exp_t e;
        ok      = 1'b0;
        i_data  = ops;
        inv     = inv_in;
        i_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (i_ready) begin
                ok    = 1'b1;
                e.val = expv;
                e.acc = cyc;
                e.lat = chk_lat;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got i_ready=0, expected 1 within 100 cycles");
        end
    endtask

    task automatic waitDrain(input string name);
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput(name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!srst && ce && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got %0h, expected no output", o_data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result", o_data, mon_e.val);
                if (mon_e.lat) checkOutput("latency", cyc - mon_e.acc, S);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [39:0] ops;
        logic [39:0] bv [6];
        logic [7:0]  be [6];
        logic        bi [6];

        srst = 1'b1; ce = 1'b1; i_data = '0; inv = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        i_data_1 = '0; inv_1 = 1'b0; i_valid_1 = 1'b0; o_ready_1 = 1'b1;
        i_data_3 = '0; inv_3 = 1'b0; i_valid_3 = 1'b0; o_ready_3 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_o", o_data, 0);
        checkOutput("rst_o_valid", o_valid, 0);
        checkOutput("rst_i_ready", i_ready, 0);
        checkOutput("rst_i_ready_1", i_ready_1, 0);
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_i_ready", i_ready, 1);
        checkOutput("post_rst_o_valid", o_valid, 0);
        @(posedge clk); #1;

        // Degenerate configurations: single operand and padded partial group.
        i_data_1 = 4'hA; inv_1 = 1'b1; i_valid_1 = 1'b1;
        i_data_3 = 12'hFFF; inv_3 = 1'b0; i_valid_3 = 1'b1;
        @(negedge clk);
        checkOutput("deg1_i_ready", i_ready_1, 1);
        checkOutput("deg3_i_ready", i_ready_3, 1);
        @(posedge clk); #1;
        i_valid_1 = 1'b0; i_valid_3 = 1'b0;
        @(negedge clk);
        checkOutput("deg1_o_valid", o_valid_1, 1);
        checkOutput("deg1_o", o_data_1, 4'h5);
        checkOutput("deg3_o_valid", o_valid_3, 1);
        checkOutput("deg3_o", o_data_3, 4'hF);
        @(posedge clk); #1;
        i_data_3 = {4'hF, 4'hE, 4'hF}; inv_3 = 1'b1; i_valid_3 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        i_valid_3 = 1'b0;
        @(negedge clk);
        checkOutput("deg3_nand_o", o_data_3, 4'h1);
        @(posedge clk); #1;

        // Basic AND and NAND.
        applyStimulus(pack5(8'hFF, 8'hF0, 8'h3C, 8'hFF, 8'hF7), 1'b0, 8'h30, 1'b1);
        applyStimulus(pack5(8'hFF, 8'hF0, 8'h3C, 8'hFF, 8'hF7), 1'b1, 8'hCF, 1'b1);
        waitDrain("basic_drain");

        // Back-to-back streaming.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < N; k++) ops[k*8 +: 8] = 8'hFF ^ (8'h01 << ((i + 2 * k) % 8));
            applyStimulus(ops, i[0], refAnd(ops, i[0]), 1'b1);
        end
        waitDrain("stream_drain");

        // Fill the pipe under backpressure, then release.
        o_ready = 1'b0;
        applyStimulus(pack5(8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 8'h0F, 1'b0);
        applyStimulus(pack5(8'h3C, 8'hFC, 8'hFF, 8'hFF, 8'hFF), 1'b0, 8'h3C, 1'b0);
        applyStimulus(pack5(8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hF3), 1'b1, 8'hED, 1'b0);
        i_data = pack5(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF); inv = 1'b0; i_valid = 1'b1;
        @(negedge clk);
        checkOutput("full_i_ready", i_ready, 0);
        checkOutput("full_o_valid", o_valid, 1);
        checkOutput("full_o", o_data, 8'h0F);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("stall_o", o_data, 8'h0F);
            checkOutput("stall_i_ready", i_ready, 0);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_i_ready", i_ready, 1);
        checkOutput("release_o_valid", o_valid, 1);
        mon_e.val = 8'hFF; mon_e.acc = cyc; mon_e.lat = 1'b0;
        sb.push_back(mon_e);
        @(posedge clk); #1;
        i_valid = 1'b0;
        waitDrain("bp_drain");

        // Bubbles with toggling O_READY.
        bv[0] = pack5(8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF); bi[0] = 1'b0; be[0] = 8'h0F;
        bv[1] = pack5(8'hAA, 8'hFF, 8'hFE, 8'hFF, 8'hFF); bi[1] = 1'b0; be[1] = 8'hAA;
        bv[2] = pack5(8'h55, 8'hF5, 8'hFF, 8'hFF, 8'h7F); bi[2] = 1'b0; be[2] = 8'h55;
        bv[3] = pack5(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF); bi[3] = 1'b1; be[3] = 8'hFF;
        bv[4] = pack5(8'h81, 8'hC3, 8'hE7, 8'hFF, 8'hFF); bi[4] = 1'b0; be[4] = 8'h81;
        bv[5] = pack5(8'hF0, 8'h0F, 8'hFF, 8'hFF, 8'hFF); bi[5] = 1'b1; be[5] = 8'hFF;
        fork
            begin
                for (int t = 0; t < 30; t++) begin
                    @(posedge clk); #1;
                    o_ready = ~o_ready;
                end
            end
            begin
                for (int v = 0; v < 6; v++) begin
                    applyStimulus(bv[v], bi[v], be[v], 1'b0);
                    @(posedge clk); #1;
                end
            end
        join
        o_ready = 1'b1;
        waitDrain("bubble_drain");

        // Clock-enable freeze with a ready consumer and a valid input pending.
        o_ready = 1'b0;
        applyStimulus(pack5(8'hC0, 8'hF0, 8'hFF, 8'hFF, 8'hFF), 1'b0, 8'hC0, 1'b0);
        applyStimulus(pack5(8'h11, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1, 8'hEE, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        ce = 1'b0; o_ready = 1'b1;
        i_data = pack5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00); inv = 1'b0; i_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checkOutput("ce_i_ready", i_ready, 0);
            checkOutput("ce_o_valid", o_valid, 1);
            checkOutput("ce_o", o_data, 8'hC0);
            @(posedge clk); #1;
        end
        ce = 1'b1; i_valid = 1'b0;
        waitDrain("ce_drain");

        // Reset with three results in flight.
        o_ready = 1'b0;
        applyStimulus(pack5(8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 8'h01, 1'b0);
        applyStimulus(pack5(8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 8'h02, 1'b0);
        applyStimulus(pack5(8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 8'h04, 1'b0);
        srst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("rst2_o", o_data, 0);
        checkOutput("rst2_o_valid", o_valid, 0);
        checkOutput("rst2_i_ready", i_ready, 0);
        @(posedge clk); #1;
        srst = 1'b0; o_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_rst2_o_valid", o_valid, 0);
        checkOutput("post_rst2_o", o_data, 0);
        checkOutput("post_rst2_i_ready", i_ready, 1);
        @(posedge clk); #1;
        applyStimulus(pack5(8'hFF, 8'hF0, 8'h3C, 8'hFF, 8'hF7), 1'b1, 8'hCF, 1'b1);
        waitDrain("rst2_drain");

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/x_andn_pipe.md
# x_andn_pipe

Parametrised, pipelined N-input AND/NAND reduction primitive for the simulation library. It is the clocked, multi-operand, multi-bit generalisation of the two-input combinational AND cell. INPUTS operands of WIDTH bits are reduced bitwise through a tree of registered stages, each combining STAGE_FANIN operands. The block carries a valid/ready handshake with per-stage bubble collapsing, and is used wherever wide AND reductions must meet timing at CLK rate.

## Interface
- INPUTS, 4, number of operands; legal 1..32
- WIDTH, 1, bits per operand and of result; legal 1..64
- STAGE_FANIN, 2, operands combined per tree node per stage; legal 2..8
- CLK  input  1  rising-edge clock
- SRST  input  1  synchronous reset, active-high; one clock, sampled on rising CLK
- CE  input  1  clock enable; low freezes all state
- I  input  INPUTS*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH]
- INV  input  1  1 = NAND result, 0 = AND; sampled with I
- I_VALID  input  1  I/INV valid this cycle
- I_READY  output  1  block accepts I this cycle
- O  output  WIDTH  reduced result
- O_VALID  output  1  O holds a valid result
- O_READY  input  1  consumer accepts O this cycle

## Operation
- Stage count: S = number of reductions needed to bring INPUTS down to 1 at STAGE_FANIN per node.
  - Minimum S is 1; INPUTS=1 gives a single registered pass-through stage.
  - Examples: INPUTS=5, FANIN=2 gives 5→3→2→1, so S=3. INPUTS=4, FANIN=4 gives S=1.
- Stage j node count = ceil(previous count / STAGE_FANIN).
  - A partial last group is padded with all-ones operands, so padding never alters the AND.
- Each stage holds: operand registers, one valid bit, and the INV bit travelling with its data.
  - Inversion is applied only at the final stage: O = INV_s ? ~AND : AND.
- Stage advance rule: stage j loads from stage j-1 when CE=1 and (stage j empty or stage j+1 loading).
  - Stage S's downstream "loading" is O_READY.
  - A bubble in any stage is absorbed without stalling upstream.
- Input acceptance: I_READY = CE & (stage 1 empty | stage 1 advancing).
  - A transfer occurs when I_VALID & I_READY.
  - I_READY is combinational from state, CE and O_READY only. It never depends on I_VALID.
- Output transfer: occurs when O_VALID & O_READY & CE.
  - O is stable while O_VALID=1 and O_READY=0.
- CE=0: no register changes, I_READY=0, no transfer; O and O_VALID hold.
- SRST=1 (priority over CE): all valid bits clear and all data registers clear.
  - O=0, O_VALID=0, I_READY=0 during the reset cycle.
- Reset mid-operation: all in-flight results are discarded; the first accept is possible on the first cycle after SRST deasserts.
- X handling: an X on any operand bit propagates per Verilog `&` semantics (0 dominates X). No filtering.

## Timing
- Latency: input accepted at edge n, result visible with O_VALID=1 after edge n+S (no backpressure).
- Throughput: one result per clock while O_READY=1 and CE=1.
- Capacity: S results in flight; with O_READY held low the pipe fills after S accepts, then I_READY=0.
- O_READY rising on a full pipe: output transfers and I_READY=1 in the same cycle (no dead cycle).
- Reset values: O=0, O_VALID=0, I_READY=0; I_READY=1 from the first non-reset cycle when CE=1.
- No combinational path from I or I_VALID to any output.

## Test plan
- Basic reduction: INPUTS=5, WIDTH=8, FANIN=2, O_READY=1. I={FF,F0,3C,FF,F7}, INV=0 accepted at edge 0 → O=0x30, O_VALID=1 after edge 3. Repeat with INV=1 → O=0xCF.
- Streaming: 16 random back-to-back vectors with O_READY=1 → 16 results, one per cycle, in order, each matching a reference model, latency exactly S.
- Backpressure/full: O_READY=0 and 4 accepts attempted with S=3 → exactly 3 accepted, I_READY=0 on the 4th, O unchanged while stalled. O_READY=1 → the 4th is accepted in the same cycle as the first output.
- Bubbles: I_VALID pattern 1,0,1,0 with O_READY toggling → no loss, no duplication, correct order.
- CE and reset: CE=0 for 5 cycles mid-stream → O/O_VALID frozen, no accepts. Then SRST pulse with 3 results in flight → O=0, O_VALID=0 next cycle, and the first post-reset result appears S cycles after its accept.
- Degenerate: INPUTS=1, WIDTH=4, I=0xA, INV=1 → O=0x5, O_VALID after 1 cycle. Padding check: INPUTS=3, FANIN=4, all operands 0xF → O=0xF.
